// File: rtl/parking_gate_arbiter.sv
// Barrier arbiter for a car park with two entry gates and one exit gate:
// grants one gate at a time, tracks occupancy and expires stalled grants.
module parking_gate_arbiter #(
  parameter int CAPACITY     = 8,
  parameter int OPEN_TIMEOUT = 16,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       entry_req,
  input  logic [1:0]       entry_done,
  input  logic             exit_req,
  input  logic             exit_done,
  output logic [1:0]       entry_grant,
  output logic             exit_grant,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             timeout_err
);

  localparam int TW = (OPEN_TIMEOUT > 2) ? $clog2(OPEN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
  localparam logic [TW-1:0]    TMO_LAST = TW'(OPEN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_ENTRY = 2'd1,
    GRANT_EXIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             gate_q, gate_d;
  logic             ptr_q, ptr_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [1:0]       egrant_q, egrant_d;
  logic             xgrant_q, xgrant_d;
  logic             tmo_q, tmo_d;

  logic can_exit;
  logic can_enter;
  logic entry_pick;
  logic expired;

  assign can_exit  = exit_req && (occ_q != '0);
  assign can_enter = (|entry_req) && (occ_q < CAP);
  // A lone requester wins outright; the pointer only breaks ties.
  assign entry_pick = (entry_req == 2'b11) ? ptr_q : entry_req[1];
  assign expired    = (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    occ_d   = occ_q;
    tmo_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_exit) begin
          state_d = GRANT_EXIT;
          cnt_d   = '0;
        end else if (can_enter) begin
          state_d = GRANT_ENTRY;
          gate_d  = entry_pick;
          cnt_d   = '0;
        end
      end

      GRANT_ENTRY: begin
        // Completion on the final cycle beats the timeout.
        if (entry_done[gate_q]) begin
          state_d = IDLE;
          occ_d   = occ_q + 1'b1;
          ptr_d   = ~ptr_q;
        end else if (expired) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          ptr_d   = ~ptr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GRANT_EXIT: begin
        if (exit_done) begin
          state_d = IDLE;
          occ_d   = occ_q - 1'b1;
        end else if (expired) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    egrant_d = {gate_d, ~gate_d} & {2{state_d == GRANT_ENTRY}};
    xgrant_d = (state_d == GRANT_EXIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gate_q   <= 1'b0;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      occ_q    <= '0;
      egrant_q <= '0;
      xgrant_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gate_q   <= gate_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      egrant_q <= egrant_d;
      xgrant_q <= xgrant_d;
      tmo_q    <= tmo_d;
    end
  end

  assign entry_grant = egrant_q;
  assign exit_grant  = xgrant_q;
  assign occupancy   = occ_q;
  assign lot_full    = (occ_q == CAP);
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed scoreboard bench for parking_gate_arbiter (CAPACITY=8, OPEN_TIMEOUT=16).
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] entry_req;
  logic [1:0] entry_done;
  logic       exit_req;
  logic       exit_done;
  logic [1:0] entry_grant;
  logic       exit_grant;
  logic [3:0] occupancy;
  logic       lot_full;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];

  parking_gate_arbiter #(
    .CAPACITY    (8),
    .OPEN_TIMEOUT(16),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .entry_req  (entry_req),
    .entry_done (entry_done),
    .exit_req   (exit_req),
    .exit_done  (exit_done),
    .entry_grant(entry_grant),
    .exit_grant (exit_grant),
    .occupancy  (occupancy),
    .lot_full   (lot_full),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Expected output vector: {entry_grant, exit_grant, occupancy, lot_full, timeout_err}
  function automatic logic [8:0] mk(input logic [1:0] eg, input logic xg, input int occ,
                                    input logic tmo);
    return {eg, xg, 4'(occ), (occ == 8), tmo};
  endfunction

  task automatic check_pop();
    exp_t       e;
    logic [8:0] obs;
    e   = sb.pop_front();
    obs = {entry_grant, exit_grant, occupancy, lot_full, timeout_err};
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed %b required %b (eg,xg,occ,full,tmo)", e.tag, obs, e.v);
    end
  endtask

  task automatic cyc(input logic [1:0] er, input logic [1:0] ed, input logic xr, input logic xd,
                     input logic [1:0] eg, input logic xg, input int occ, input logic tmo,
                     input string tag);
    exp_t e;
    entry_req  = er;
    entry_done = ed;
    exit_req   = xr;
    exit_done  = xd;
    e.tag = tag;
    e.v   = mk(eg, xg, occ, tmo);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    entry_req  = 2'b00;
    entry_done = 2'b00;
    exit_req   = 1'b0;
    exit_done  = 1'b0;
    reset      = 1'b1;
    #1;
    e.tag = tag;
    e.v   = mk(2'b00, 1'b0, 0, 1'b0);
    sb.push_back(e);
    check_pop();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [1:0] g;

    reset      = 1'b1;
    entry_req  = 2'b00;
    entry_done = 2'b00;
    exit_req   = 1'b0;
    exit_done  = 1'b0;
    @(posedge clk);
    #1;
    e.tag = "reset_state";
    e.v   = mk(2'b00, 1'b0, 0, 1'b0);
    sb.push_back(e);
    check_pop();
    reset = 1'b0;

    // Single entry, then done
    cyc(2'b01, 2'b00, 0, 0, 2'b01, 0, 0, 0, "t1_grant");
    cyc(2'b00, 2'b01, 0, 0, 2'b00, 0, 1, 0, "t1_done");
    cyc(2'b00, 2'b00, 0, 0, 2'b00, 0, 1, 0, "t1_idle");
    cyc(2'b00, 2'b01, 0, 0, 2'b00, 0, 1, 0, "idle_done_ignored");

    // Both entries requesting: alternate starting at gate 0
    do_reset("t2_reset");
    for (int i = 0; i < 4; i++) begin
      g = i[0] ? 2'b10 : 2'b01;
      cyc(2'b11, 2'b00, 0, 0, g, 0, i, 0, "t2_grant");
      cyc(2'b11, 2'b00, 0, 0, g, 0, i, 0, "t2_hold1");
      cyc(2'b11, 2'b00, 0, 0, g, 0, i, 0, "t2_hold2");
      cyc(2'b11, g, 0, 0, 2'b00, 0, i + 1, 0, "t2_done");
    end
    cyc(2'b00, 2'b00, 0, 0, 2'b00, 0, 4, 0, "t2_idle");

    // Fill to capacity, then pending entry served after an exit
    for (int i = 4; i < 8; i++) begin
      cyc(2'b01, 2'b00, 0, 0, 2'b01, 0, i, 0, "t3_fill_grant");
      cyc(2'b00, 2'b01, 0, 0, 2'b00, 0, i + 1, 0, "t3_fill_done");
    end
    for (int i = 0; i < 3; i++)
      cyc(2'b01, 2'b00, 0, 0, 2'b00, 0, 8, 0, "t3_full_pending");
    cyc(2'b01, 2'b00, 1, 0, 2'b00, 1, 8, 0, "t3_exit_grant");
    cyc(2'b01, 2'b00, 0, 1, 2'b00, 0, 7, 0, "t3_exit_done");
    cyc(2'b01, 2'b00, 0, 0, 2'b01, 0, 7, 0, "t3_entry_after_exit");
    cyc(2'b00, 2'b01, 0, 0, 2'b00, 0, 8, 0, "t3_refill");

    // Exit at zero ignored; exit priority over simultaneous entry
    do_reset("t4_reset");
    cyc(2'b00, 2'b00, 1, 0, 2'b00, 0, 0, 0, "exit_empty_ignored");
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 2'b00, 0, 0, 2'b01, 0, i, 0, "t4_fill_grant");
      cyc(2'b00, 2'b01, 0, 0, 2'b00, 0, i + 1, 0, "t4_fill_done");
    end
    cyc(2'b10, 2'b00, 1, 0, 2'b00, 1, 3, 0, "t4_exit_first");
    cyc(2'b10, 2'b00, 0, 1, 2'b00, 0, 2, 0, "t4_exit_done");
    cyc(2'b10, 2'b00, 0, 0, 2'b10, 0, 2, 0, "t4_entry_after");
    cyc(2'b00, 2'b10, 0, 0, 2'b00, 0, 3, 0, "t4_entry_done");

    // Timeout: grant held exactly 16 cycles, one-cycle error, pointer advances
    cyc(2'b01, 2'b00, 0, 0, 2'b01, 0, 3, 0, "t5_grant");
    for (int k = 1; k < 16; k++)
      cyc(2'b00, 2'b00, 0, 0, 2'b01, 0, 3, 0, "t5_hold");
    cyc(2'b00, 2'b00, 0, 0, 2'b00, 0, 3, 1, "t5_timeout");
    cyc(2'b00, 2'b00, 0, 0, 2'b00, 0, 3, 0, "t5_err_one_cycle");
    cyc(2'b11, 2'b00, 0, 0, 2'b10, 0, 3, 0, "t5_ptr_advanced");
    cyc(2'b00, 2'b10, 0, 0, 2'b00, 0, 4, 0, "t5_done");

    // Done on the last allowed cycle wins over timeout; stray dones ignored
    cyc(2'b01, 2'b00, 0, 0, 2'b01, 0, 4, 0, "t5b_grant");
    for (int k = 1; k < 16; k++) begin
      if (k == 7)
        cyc(2'b00, 2'b10, 0, 0, 2'b01, 0, 4, 0, "t5b_stray_entry_done");
      else if (k == 8)
        cyc(2'b00, 2'b00, 0, 1, 2'b01, 0, 4, 0, "t5b_stray_exit_done");
      else
        cyc(2'b00, 2'b00, 0, 0, 2'b01, 0, 4, 0, "t5b_hold");
    end
    cyc(2'b00, 2'b01, 0, 0, 2'b00, 0, 5, 0, "t5b_done_at_limit");
    cyc(2'b00, 2'b00, 0, 0, 2'b00, 0, 5, 0, "t5b_no_err");

    // Reset mid-grant
    cyc(2'b01, 2'b00, 0, 0, 2'b01, 0, 5, 0, "t6_grant");
    do_reset("t6_reset_mid_grant");
    cyc(2'b00, 2'b01, 0, 0, 2'b00, 0, 0, 0, "t6_stray_done");
    cyc(2'b01, 2'b00, 0, 0, 2'b01, 0, 0, 0, "t6_regrant");
    cyc(2'b00, 2'b01, 0, 0, 2'b00, 0, 1, 0, "t6_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
